// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate data cache in front of a fixed-latency
// pipelined word memory. Hits complete in the request cycle; misses stall the requester.
module dm_cache #(
  parameter int LINES   = 8,
  parameter int WORDS   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 15 - OFF_W - IDX_W;
  localparam int CNT_W = $clog2(WORDS + MEM_LAT + 1);

  localparam logic [CNT_W-1:0] C_WB_LAST   = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] C_WORDS     = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] C_LAT       = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] C_FILL_LAST = CNT_W'(WORDS + MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    ALLOC = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [15:0]        r_data [LINES][WORDS];

  logic [OFF_W-1:0]   w_off;
  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_bad_req;
  logic               w_legal;
  logic               w_hit;
  logic [15:0]        w_rd_word;
  logic [OFF_W-1:0]   w_fill_off;
  logic               w_dwe;
  logic [OFF_W-1:0]   w_dwoff;
  logic [15:0]        w_dwdata;
  logic               w_twe;

  assign w_off      = Addr[OFF_W:1];
  assign w_idx      = Addr[OFF_W+IDX_W:OFF_W+1];
  assign w_tag      = Addr[15:OFF_W+IDX_W+1];
  assign w_bad_req  = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
  assign w_legal    = (Rd ^ Wr) & ~Addr[0];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rd_word  = r_data[w_idx][w_off];
  // r_cnt counts ALLOC cycles; the return for offset k lands at count k+MEM_LAT
  assign w_fill_off = OFF_W'(r_cnt - C_LAT);
  assign w_twe      = !rst && (r_state == ALLOC) && (r_cnt == C_FILL_LAST);

  // Control FSM with valid/dirty bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_valid <= {LINES{1'b0}};
      r_dirty <= {LINES{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_legal && !w_hit) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? WB : ALLOC;
          end else if (w_legal && Wr) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        WB: begin
          if (r_cnt == C_WB_LAST) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= ALLOC;
          end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ALLOC: begin
          if (r_cnt == C_FILL_LAST) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_cnt          <= {CNT_W{1'b0}};
            r_state        <= FIN;
          end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        FIN: begin
          if (Wr) begin
            r_dirty[w_idx] <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data-array write port select: hit write, refill return, or FIN merge
  always_comb begin
    w_dwe    = 1'b0;
    w_dwoff  = w_off;
    w_dwdata = DataIn;
    if (rst) begin
      w_dwe = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_legal && w_hit && Wr) begin
            w_dwe = 1'b1;
          end else begin
            w_dwe = 1'b0;
          end
        end
        ALLOC: begin
          if (r_cnt >= C_LAT) begin
            w_dwe    = 1'b1;
            w_dwoff  = w_fill_off;
            w_dwdata = mem_rdata;
          end else begin
            w_dwe = 1'b0;
          end
        end
        FIN:     w_dwe = Wr;
        default: w_dwe = 1'b0;
      endcase
    end
  end

  // Tag and data arrays, intentionally not reset
  always_ff @(posedge clk) begin
    if (w_dwe) begin
      r_data[w_idx][w_dwoff] <= w_dwdata;
    end
    if (w_twe) begin
      r_tag[w_idx] <= w_tag;
    end
  end

  // Requester and memory-side outputs, forced low while reset is asserted
  always_comb begin
    Done      = 1'b0;
    Stall     = 1'b0;
    CacheHit  = 1'b0;
    err       = 1'b0;
    DataOut   = 16'h0000;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (rst) begin
      Done = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_bad_req) begin
            err = 1'b1;
          end else if (w_legal && w_hit) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            DataOut  = Rd ? w_rd_word : 16'h0000;
          end else if (w_legal) begin
            Stall = 1'b1;
          end else begin
            Stall = 1'b0;
          end
        end
        WB: begin
          Stall     = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = {r_tag[w_idx], w_idx, r_cnt[OFF_W-1:0], 1'b0};
          mem_wdata = r_data[w_idx][r_cnt[OFF_W-1:0]];
        end
        ALLOC: begin
          Stall = 1'b1;
          if (r_cnt < C_WORDS) begin
            mem_rd   = 1'b1;
            mem_addr = {w_tag, w_idx, r_cnt[OFF_W-1:0], 1'b0};
          end else begin
            mem_rd = 1'b0;
          end
        end
        FIN: begin
          Done    = 1'b1;
          DataOut = Rd ? w_rd_word : 16'h0000;
        end
        default: Done = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache.sv
// Bench for dm_cache: request table against a logical memory image, plus a
// scoreboard queue of expected memory-side transfers.
module tb_dm_cache;
  localparam int WORDS   = 4;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
  logic        Rd, Wr, Done, Stall, CacheHit, err, mem_rd, mem_wr;

  dm_cache #(.LINES(8), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    bit          is_err;
    bit          hit;
    bit          wb;
    logic [15:0] victim;
  } vec_t;

  typedef struct packed {
    logic        is_wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } mop_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [15:0] mem     [32768];
  logic [15:0] ref_mem [32768];
  logic [15:0] pa [MEM_LAT];
  logic        pv [MEM_LAT];
  mop_t        exp_q [$];
  vec_t        vt [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model and memory-traffic scoreboard, sampled mid-cycle
  initial begin
    mop_t m;
    for (int j = 0; j < MEM_LAT; j++) begin
      pv[j] = 1'b0;
      pa[j] = 16'h0000;
    end
    mem_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (!rst && (mem_rd || mem_wr)) begin
        chk("mem_rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_traffic: got rd=%0b wr=%0b addr %h, expected none", mem_rd, mem_wr, mem_addr);
        end else begin
          m = exp_q.pop_front();
          chk("mem_kind", 32'(mem_wr), 32'(m.is_wr));
          chk("mem_addr", 32'(mem_addr), 32'(m.addr));
          chk("mem_cycle", 32'(cyc), m.cyc);
          if (m.is_wr) chk("mem_wdata", 32'(mem_wdata), 32'(m.data));
        end
      end
      mem_rdata = pv[MEM_LAT-1] ? mem[pa[MEM_LAT-1][15:1]] : 16'hDEAD;
      for (int j = MEM_LAT - 1; j > 0; j--) begin
        pv[j] = pv[j-1];
        pa[j] = pa[j-1];
      end
      pv[0] = mem_rd & ~rst;
      pa[0] = mem_addr;
      if (!rst && mem_wr) mem[mem_addr[15:1]] = mem_wdata;
    end
  end

  task automatic apply(input vec_t v);
    int          rc;
    int          lat;
    int          n;
    int          off;
    bit          stall_ok;
    logic [15:0] base;
    mop_t        m;
    @(posedge clk);
    #1;
    Rd = v.rd; Wr = v.wr; Addr = v.addr; DataIn = v.din;
    rc = cyc;
    if (v.is_err) begin
      #1;
      chk("err_flag", 32'(err), 32'd1);
      chk("err_done_stall", 32'({Done, Stall}), 32'd0);
      chk("err_mem_traffic", 32'({mem_rd, mem_wr}), 32'd0);
    end else begin
      off = v.wb ? WORDS : 0;
      if (!v.hit) begin
        for (int k = 0; k < off; k++) begin
          m.is_wr = 1'b1;
          m.addr  = v.victim + 16'(2 * k);
          m.data  = ref_mem[v.victim[15:1] + 15'(k)];
          m.cyc   = 32'(rc + 1 + k);
          exp_q.push_back(m);
        end
        base = v.addr & 16'hFFF8;
        for (int k = 0; k < WORDS; k++) begin
          m.is_wr = 1'b0;
          m.addr  = base + 16'(2 * k);
          m.data  = 16'h0000;
          m.cyc   = 32'(rc + 1 + off + k);
          exp_q.push_back(m);
        end
      end
      lat = v.hit ? 0 : (v.wb ? 2 * WORDS + MEM_LAT + 1 : WORDS + MEM_LAT + 1);
      stall_ok = 1'b1;
      for (n = 0; n <= 20; n++) begin
        @(negedge clk);
        if (Done) break;
        if (!Stall) stall_ok = 1'b0;
      end
      chk("done_latency", 32'(n), 32'(lat));
      chk("cache_hit", 32'(CacheHit), 32'(v.hit));
      chk("stall_profile", 32'({stall_ok, Stall}), 32'b10);
      if (v.rd) chk("read_data", 32'(DataOut), 32'(ref_mem[v.addr[15:1]]));
      if (v.wr) ref_mem[v.addr[15:1]] = v.din;
    end
    @(posedge clk);
    #1;
    Rd = 1'b0; Wr = 1'b0;
    #1;
    chk("idle_outputs", 32'({Done, Stall, CacheHit, err, mem_rd, mem_wr, DataOut}), 32'd0);
  endtask

  initial begin
    int   rc;
    mop_t m;
    rst = 1'b1; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010; DataIn = 16'h0000;
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 16'(i) ^ 16'hC3A5;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[8 + i]     = 16'h1111 * 16'(i + 1);
      ref_mem[8 + i] = mem[8 + i];
    end

    //       rd    wr    addr      din       err   hit   wb    victim
    vt[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[1]  = '{1'b1, 1'b0, 16'h0014, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[2]  = '{1'b0, 1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[3]  = '{1'b1, 1'b0, 16'h0412, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0010};
    vt[4]  = '{1'b1, 1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
    vt[5]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
    vt[6]  = '{1'b0, 1'b1, 16'h0100, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[7]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[8]  = '{1'b1, 1'b0, 16'h0106, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[9]  = '{1'b0, 1'b1, 16'h0104, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[10] = '{1'b1, 1'b0, 16'h0500, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0100};
    vt[11] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[12] = '{1'b0, 1'b1, 16'h001E, 16'h7777, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[13] = '{1'b1, 1'b0, 16'h001E, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[14] = '{1'b1, 1'b0, 16'h0412, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[15] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};

    #2;
    chk("reset_ctrl_outputs", 32'({Done, Stall, CacheHit, err, mem_rd, mem_wr}), 32'd0);
    chk("reset_data_outputs", {DataOut, mem_addr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_held_outputs", 32'({Done, Stall, CacheHit, err, mem_rd, mem_wr, mem_wdata}), 32'd0);
    rst = 1'b0; Rd = 1'b0;

    for (int i = 0; i < 16; i++) apply(vt[i]);

    // Reset in the middle of a refill: only the first two reads get out
    @(posedge clk);
    #1;
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0030;
    rc = cyc;
    for (int k = 0; k < 2; k++) begin
      m.is_wr = 1'b0;
      m.addr  = 16'h0030 + 16'(2 * k);
      m.data  = 16'h0000;
      m.cyc   = 32'(rc + 1 + k);
      exp_q.push_back(m);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_mem_rd", 32'(mem_rd), 32'd1);
    rst = 1'b1;
    #1;
    chk("midfill_reset_mem_rd", 32'(mem_rd), 32'd0);
    chk("midfill_reset_stall", 32'({Stall, Done, err}), 32'd0);
    Rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply('{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000});
    apply('{1'b1, 1'b0, 16'h0412, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000});

    repeat (3) @(posedge clk);
    chk("traffic_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
